xoshiro128p_jump_ctrl: RTL and testbench

//  Sits directly upstream of the xoshiro128+ PRNG and drives its clock-gate and seed-load

---
 rtl/prng_xoshiro128p_pkg.sv | 28 ++
 rtl/xoshiro128p_jump_ctrl.sv | 130 +++++++++++++
 tb/tb_xoshiro128p_jump_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prng_xoshiro128p_pkg.sv
// Shared types and jump polynomials for the xoshiro128+ jump controller.
// Polynomials are written in C array order: C word 0 is the leftmost 32-bit field.
package prng_xoshiro128p_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_LOAD,
        ST_DONE
    } jumpState_e;

    // Element k holds PRNG word s[k].
    typedef logic [3:0][31:0] prngState_t;

    localparam logic [127:0] JUMP      = {32'h8764000b, 32'hf542d2d3, 32'h6fa035c3, 32'h77f2db5b};
    localparam logic [127:0] LONG_JUMP = {32'hb523952e, 32'h0b6f099f, 32'hccf5a0ef, 32'h1c580662};
    localparam logic [6:0]   IDX_LAST  = 7'd127;

    // Bit idx of the selected polynomial: C word idx>>5 first, LSB first within each word.
    function automatic logic jumpBit(input logic isLong, input logic [6:0] idx);
        logic [127:0] poly;
        logic [6:0]   pos;
        poly = isLong ? LONG_JUMP : JUMP;
        pos  = {2'd3 - idx[6:5], idx[4:0]};
        return poly[pos];
    endfunction

endpackage

// File: rtl/xoshiro128p_jump_ctrl.sv
// Hardware jump()/long_jump() sequencer sitting in front of a xoshiro128+ PRNG.
// In IDLE the user seed and clock-gate pass straight through to the PRNG.
module xoshiro128p_jump_ctrl
    import prng_xoshiro128p_pkg::*;
#(
    parameter logic LONG_JUMP_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_cg,
    input  logic        i_seedValid,
    input  logic [31:0] i_seedS0,
    input  logic [31:0] i_seedS1,
    input  logic [31:0] i_seedS2,
    input  logic [31:0] i_seedS3,
    input  logic        i_jump,
    input  logic        i_longJump,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_prngCg,
    output logic        o_prngSeedValid,
    output logic [31:0] o_prngSeedS0,
    output logic [31:0] o_prngSeedS1,
    output logic [31:0] o_prngSeedS2,
    output logic [31:0] o_prngSeedS3,
    input  logic [31:0] i_prngS0,
    input  logic [31:0] i_prngS1,
    input  logic [31:0] i_prngS2,
    input  logic [31:0] i_prngS3
);

    jumpState_e state_q;
    logic [6:0] idx_q, idx_d;
    prngState_t acc_q, acc_d;
    prngState_t prngS;
    logic       isLong_q;
    logic       done_q;
    logic       longSel;
    logic       startReq;
    logic       passThru;

    assign prngS    = {i_prngS3, i_prngS2, i_prngS1, i_prngS0};
    assign longSel  = i_longJump & LONG_JUMP_EN;
    assign startReq = (i_jump | longSel) & i_cg & ~i_seedValid;

    // A user seed always wins, even mid-sequence, so the PRNG sees it in the same cycle.
    assign passThru = (state_q == ST_IDLE) | i_seedValid;

    // acc is XORed with the PRNG state before the step that happens on this same edge.
    assign idx_d = (idx_q == IDX_LAST) ? idx_q : idx_q + 7'd1;
    assign acc_d = jumpBit(isLong_q, idx_q) ? (acc_q ^ prngS) : acc_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            isLong_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (i_seedValid && (state_q != ST_IDLE)) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (startReq) begin
                            state_q  <= ST_RUN;
                            idx_q    <= '0;
                            acc_q    <= '0;
                            isLong_q <= longSel;
                        end
                    end
                    ST_RUN: begin
                        if (i_cg) begin
                            acc_q <= acc_d;
                            idx_q <= idx_d;
                            if (idx_q == IDX_LAST) begin
                                state_q <= ST_LOAD;
                            end
                        end
                    end
                    ST_LOAD: begin
                        state_q <= ST_DONE;
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        o_prngCg        = i_cg | i_seedValid;
        o_prngSeedValid = i_seedValid;
        o_prngSeedS0    = i_seedS0;
        o_prngSeedS1    = i_seedS1;
        o_prngSeedS2    = i_seedS2;
        o_prngSeedS3    = i_seedS3;
        if (!passThru) begin
            o_prngSeedS0 = acc_q[0];
            o_prngSeedS1 = acc_q[1];
            o_prngSeedS2 = acc_q[2];
            o_prngSeedS3 = acc_q[3];
            case (state_q)
                ST_RUN: begin
                    o_prngCg        = i_cg;
                    o_prngSeedValid = 1'b0;
                end
                ST_LOAD: begin
                    o_prngCg        = 1'b1;
                    o_prngSeedValid = 1'b1;
                end
                default: begin
                    o_prngCg        = 1'b0;
                    o_prngSeedValid = 1'b0;
                end
            endcase
        end
    end

    assign o_busy = (state_q != ST_IDLE);
    assign o_done = done_q;

endmodule

// File: tb/tb_xoshiro128p_jump_ctrl.sv
// Bench: two controllers (long jump enabled / disabled), each driving its own xoshiro128+ model,
// compared against C-level next()/jump()/long_jump() reference functions.
module tb_xoshiro128p_jump_ctrl;

    typedef logic [3:0][31:0] st_t;

    typedef struct {
        logic        cg;
        logic        sv;
        logic        jmp;
        logic        lng;
        logic [31:0] word;
        logic        expCg;
        logic        expSv;
    } vec_t;

    logic        i_clk;
    logic        i_rstn;
    logic        i_cg;
    logic        i_seedValid;
    logic [31:0] i_seedS0, i_seedS1, i_seedS2, i_seedS3;
    logic        i_jump;
    logic        i_longJump;

    logic        o_busy, o_done, o_prngCg, o_prngSeedValid;
    logic [31:0] o_prngSeedS0, o_prngSeedS1, o_prngSeedS2, o_prngSeedS3;
    logic        busy0, done0, prngCg0, prngSv0;
    logic [31:0] seedOut0S0, seedOut0S1, seedOut0S2, seedOut0S3;

    st_t         pS;
    st_t         pS0;
    logic [31:0] prngResult;

    int          errors = 0;
    int          checks = 0;
    st_t         modelS;
    st_t         model0;
    st_t         lastJumped;
    st_t         golden2;
    st_t         seed1234;
    vec_t        vecs[6];

    xoshiro128p_jump_ctrl #(.LONG_JUMP_EN(1'b1)) u_dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_cg(i_cg), .i_seedValid(i_seedValid),
        .i_seedS0(i_seedS0), .i_seedS1(i_seedS1), .i_seedS2(i_seedS2), .i_seedS3(i_seedS3),
        .i_jump(i_jump), .i_longJump(i_longJump),
        .o_busy(o_busy), .o_done(o_done), .o_prngCg(o_prngCg), .o_prngSeedValid(o_prngSeedValid),
        .o_prngSeedS0(o_prngSeedS0), .o_prngSeedS1(o_prngSeedS1),
        .o_prngSeedS2(o_prngSeedS2), .o_prngSeedS3(o_prngSeedS3),
        .i_prngS0(pS[0]), .i_prngS1(pS[1]), .i_prngS2(pS[2]), .i_prngS3(pS[3])
    );

    xoshiro128p_jump_ctrl #(.LONG_JUMP_EN(1'b0)) u_dut0 (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_cg(i_cg), .i_seedValid(i_seedValid),
        .i_seedS0(i_seedS0), .i_seedS1(i_seedS1), .i_seedS2(i_seedS2), .i_seedS3(i_seedS3),
        .i_jump(i_jump), .i_longJump(i_longJump),
        .o_busy(busy0), .o_done(done0), .o_prngCg(prngCg0), .o_prngSeedValid(prngSv0),
        .o_prngSeedS0(seedOut0S0), .o_prngSeedS1(seedOut0S1),
        .o_prngSeedS2(seedOut0S2), .o_prngSeedS3(seedOut0S3),
        .i_prngS0(pS0[0]), .i_prngS1(pS0[1]), .i_prngS2(pS0[2]), .i_prngS3(pS0[3])
    );

    // C reference: one xoshiro128+ next() state update.
    function automatic st_t refNext(input st_t s);
        st_t         r;
        logic [31:0] t;
        r = s;
        t = r[1] << 9;
        r[2] = r[2] ^ r[0];
        r[3] = r[3] ^ r[1];
        r[1] = r[1] ^ r[2];
        r[0] = r[0] ^ r[3];
        r[2] = r[2] ^ t;
        r[3] = {r[3][20:0], r[3][31:21]};
        return r;
    endfunction

    function automatic logic [31:0] refResult(input st_t s);
        return s[0] + s[3];
    endfunction

    // C reference: jump() / long_jump() loop over the table words and bits.
    function automatic st_t refJump(input st_t s, input logic isLong);
        logic [31:0] k [4];
        st_t         acc;
        st_t         cur;
        if (isLong) k = '{32'hb523952e, 32'h0b6f099f, 32'hccf5a0ef, 32'h1c580662};
        else        k = '{32'h8764000b, 32'hf542d2d3, 32'h6fa035c3, 32'h77f2db5b};
        acc = '0;
        cur = s;
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 32; b++) begin
                if (k[i][b]) acc = acc ^ cur;
                cur = refNext(cur);
            end
        end
        return acc;
    endfunction

    // PRNG models driven by the controllers.
    always @(posedge i_clk) begin
        if (o_prngCg) pS <= o_prngSeedValid ? {o_prngSeedS3, o_prngSeedS2, o_prngSeedS1, o_prngSeedS0}
                                            : refNext(pS);
        if (prngCg0) pS0 <= prngSv0 ? {seedOut0S3, seedOut0S2, seedOut0S1, seedOut0S0}
                                    : refNext(pS0);
    end

    assign prngResult = pS[0] + pS[3];

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic cg, input logic sv, input logic jmp, input logic lng, input st_t seed);
        i_cg        = cg;
        i_seedValid = sv;
        i_jump      = jmp;
        i_longJump  = lng;
        i_seedS0    = seed[0];
        i_seedS1    = seed[1];
        i_seedS2    = seed[2];
        i_seedS3    = seed[3];
    endtask

    task automatic loadSeed(input st_t s);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, s);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        modelS = s;
        model0 = s;
    endtask

    // Start a jump, gate advance with probability cgPct%, then check latency, state and 8 results.
    task automatic doJump(input logic jmp, input logic lng, input int cgPct);
        int   ones;
        int   zeros;
        int   doneCyc;
        logic done0Seen;
        modelS = refJump(refNext(modelS), lng);
        if (jmp) model0 = refJump(refNext(model0), 1'b0);
        applyStimulus(1'b1, 1'b0, jmp, lng, '0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("busy_at_start", 128'(o_busy), 128'(1'b1));
        checkOutput("busy0_at_start", 128'(busy0), 128'(jmp));
        ones      = 0;
        zeros     = 0;
        doneCyc   = 0;
        done0Seen = 1'b0;
        for (int cyc = 1; cyc <= 1000; cyc++) begin
            if (ones < 128) begin
                i_cg = (int'($urandom_range(0, 99)) < cgPct);
                if (i_cg) ones++;
                else      zeros++;
            end else begin
                i_cg = 1'b0;
            end
            tick();
            if (done0) done0Seen = 1'b1;
            if (o_done) begin
                doneCyc = cyc;
                break;
            end
        end
        i_cg = 1'b0;
        checkOutput("done_latency", 128'(doneCyc), 128'(130 + zeros));
        checkOutput("done0_pulse", 128'(done0Seen), 128'(jmp));
        lastJumped = pS;
        checkOutput("jumped_state", pS, modelS);
        if (jmp) checkOutput("jumped_state_en0", pS0, model0);
        tick();
        checkOutput("done_one_cycle", 128'(o_done), 128'(1'b0));
        checkOutput("busy_after_done", 128'(o_busy), 128'(1'b0));
        for (int i = 0; i < 8; i++) begin
            checkOutput("result_seq", 128'(prngResult), 128'(refResult(modelS)));
            i_cg = 1'b1;
            tick();
            modelS = refNext(modelS);
            if (jmp) model0 = refNext(model0);
        end
        i_cg = 1'b0;
    endtask

    initial begin
        int   sel;
        int   doneCount;
        st_t  rs;
        seed1234 = {32'd4, 32'd3, 32'd2, 32'd1};
        golden2  = refJump(refNext(seed1234), 1'b0);
        pS       = '0;
        pS0      = '0;
        modelS   = '0;
        model0   = '0;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1111, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h2222_0000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hdead_beef, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0001, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0f0f_f0f0, 1'b1, 1'b1};

        i_rstn = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        checkOutput("reset_busy", 128'(o_busy), 128'(1'b0));
        checkOutput("reset_done", 128'(o_done), 128'(1'b0));
        checkOutput("reset_prngCg", 128'(o_prngCg), 128'(1'b0));
        i_rstn = 1'b1;
        tick();

        $display("[TB] idle pass-through vectors");
        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].cg, vecs[v].sv, vecs[v].jmp, vecs[v].lng,
                          {vecs[v].word ^ 32'd3, vecs[v].word ^ 32'd2, vecs[v].word ^ 32'd1, vecs[v].word});
            #1;
            checkOutput("vec_prngCg", 128'(o_prngCg), 128'(vecs[v].expCg));
            checkOutput("vec_prngSv", 128'(o_prngSeedValid), 128'(vecs[v].expSv));
            checkOutput("vec_seedS0", 128'(o_prngSeedS0), 128'(vecs[v].word));
            checkOutput("vec_seedS3", 128'(o_prngSeedS3), 128'(vecs[v].word ^ 32'd3));
            tick();
            checkOutput("vec_no_start", 128'(o_busy), 128'(1'b0));
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        end

        $display("[TB] seed and single step");
        loadSeed(seed1234);
        checkOutput("t1_state", pS, seed1234);
        checkOutput("t1_result", 128'(prngResult), 128'(32'd5));
        i_cg = 1'b1;
        tick();
        i_cg = 1'b0;
        modelS = refNext(modelS);
        checkOutput("t1_step_result", 128'(prngResult), 128'(refResult(modelS)));
        checkOutput("t1_busy", 128'(o_busy), 128'(1'b0));

        $display("[TB] jump");
        loadSeed(seed1234);
        doJump(1'b1, 1'b0, 100);
        checkOutput("t2_golden", lastJumped, golden2);

        $display("[TB] long jump with both requests, then long only");
        loadSeed(seed1234);
        doJump(1'b1, 1'b1, 100);
        checkOutput("t3_long_golden", lastJumped, refJump(refNext(seed1234), 1'b1));
        loadSeed(seed1234);
        doJump(1'b0, 1'b1, 100);

        $display("[TB] jump with random advance gating");
        loadSeed(seed1234);
        doJump(1'b1, 1'b0, 50);
        checkOutput("t4_same_as_t2", lastJumped, golden2);

        $display("[TB] abort by seed load");
        loadSeed(seed1234);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0);
        tick();
        i_jump = 1'b0;
        for (int i = 0; i < 60; i++) tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, {4{32'd9}});
        #1;
        checkOutput("abort_passthru_sv", 128'(o_prngSeedValid), 128'(1'b1));
        checkOutput("abort_passthru_cg", 128'(o_prngCg), 128'(1'b1));
        checkOutput("abort_passthru_s1", 128'(o_prngSeedS1), 128'(32'd9));
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("abort_busy", 128'(o_busy), 128'(1'b0));
        doneCount = 0;
        for (int i = 0; i < 140; i++) begin
            tick();
            if (o_done || done0) doneCount++;
        end
        checkOutput("abort_no_done", 128'(doneCount), 128'(0));
        checkOutput("abort_prng_held", pS, {4{32'd9}});
        modelS = {4{32'd9}};
        model0 = {4{32'd9}};
        doJump(1'b1, 1'b0, 100);

        $display("[TB] async reset mid-sequence");
        loadSeed(seed1234);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0);
        tick();
        i_jump = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        #2;
        i_rstn = 1'b0;
        #1;
        checkOutput("reset_async_busy", 128'(o_busy), 128'(1'b0));
        checkOutput("reset_async_busy0", 128'(busy0), 128'(1'b0));
        i_cg = 1'b0;
        tick();
        i_rstn = 1'b1;
        tick();
        loadSeed(seed1234);
        doJump(1'b1, 1'b0, 100);
        checkOutput("t6_golden", lastJumped, golden2);

        $display("[TB] random seeds and requests");
        for (int r = 0; r < 4; r++) begin
            rs  = {$urandom, $urandom, $urandom, $urandom};
            sel = int'($urandom_range(1, 3));
            loadSeed(rs);
            doJump(sel[0], sel[1], 50);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
